// File: rtl/arm_pipelined_mem_pkg.sv
// Shared types and helpers for the pipelined ARM data-memory responder.
package arm_pipelined_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // The address is zero-extended to 64 bits so that one helper serves every bus width.
  function automatic logic is_fault(input logic [63:0] addr, input int unsigned depth_words);
    logic [63:0] limit;
    limit    = 64'(depth_words) << 2;
    is_fault = (addr[1:0] != 2'b00) || (addr >= limit);
  endfunction

endpackage

// File: rtl/arm_pipelined_word_ram.sv
// Word storage: synchronous write, combinational read, contents not reset.
module arm_pipelined_word_ram #(
  parameter int BusWidth   = 32,
  parameter int DepthWords = 64,
  localparam int AW        = $clog2(DepthWords)
) (
  input  logic                clk,
  input  logic                we,
  input  logic [AW-1:0]       addr,
  input  logic [BusWidth-1:0] wdata,
  output logic [BusWidth-1:0] rdata
);

  logic [BusWidth-1:0] mem [DepthWords];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/arm_pipelined_data_memory_responder.sv
// Fixed-latency data memory for the MEM stage; stalls the pipeline while an access is in flight.
module arm_pipelined_data_memory_responder
  import arm_pipelined_mem_pkg::*;
#(
  parameter int BusWidth   = 32,
  parameter int DepthWords = 64,
  parameter int Latency    = 2
) (
  input  logic                i_CLK,
  input  logic                i_RESET,
  input  logic                i_MemRequest,
  input  logic                i_MemWrite,
  input  logic [BusWidth-1:0] i_Address,
  input  logic [BusWidth-1:0] i_WriteData,
  output logic [BusWidth-1:0] o_ReadData,
  output logic                o_Ready,
  output logic                o_Stall,
  output logic                o_Fault
);

  localparam int AW = $clog2(DepthWords);
  localparam int CW = $clog2(Latency) + 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(Latency - 1);

  state_t              state, next_state;
  logic [CW-1:0]       cnt;
  logic                cap_write;
  logic [BusWidth-1:0] cap_addr;
  logic [BusWidth-1:0] cap_data;
  logic [BusWidth-1:0] read_data;
  logic                ready;
  logic                fault;

  logic                acc_fault;
  logic                acc_done;
  logic                ram_we;
  logic [BusWidth-1:0] ram_rdata;

  assign acc_fault = is_fault(64'(cap_addr), DepthWords);
  assign acc_done  = (state == WAIT) && (cnt == '0);
  // Gated by state, so an asynchronous reset mid-WAIT drops a pending store.
  assign ram_we    = acc_done && cap_write && !acc_fault;

  arm_pipelined_word_ram #(
    .BusWidth  (BusWidth),
    .DepthWords(DepthWords)
  ) u_ram (
    .clk  (i_CLK),
    .we   (ram_we),
    .addr (cap_addr[AW+1:2]),
    .wdata(cap_data),
    .rdata(ram_rdata)
  );

  always_ff @(posedge i_CLK or posedge i_RESET) begin
    if (i_RESET) state <= IDLE;
    else         state <= next_state;
  end

  always_comb begin
    next_state = state;
    o_Stall    = 1'b0;
    case (state)
      IDLE: begin
        o_Stall = i_MemRequest;
        if (i_MemRequest) next_state = WAIT;
      end
      WAIT: begin
        o_Stall = 1'b1;
        if (cnt == '0) next_state = RESP;
      end
      RESP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge i_CLK or posedge i_RESET) begin
    if (i_RESET) begin
      cnt       <= '0;
      cap_write <= 1'b0;
      cap_addr  <= '0;
      cap_data  <= '0;
      read_data <= '0;
      ready     <= 1'b0;
      fault     <= 1'b0;
    end else begin
      ready <= 1'b0;
      case (state)
        IDLE: begin
          if (i_MemRequest) begin
            cap_write <= i_MemWrite;
            cap_addr  <= i_Address;
            cap_data  <= i_WriteData;
            cnt       <= CNT_INIT;
            fault     <= 1'b0;
          end
        end
        WAIT: begin
          if (cnt != '0) begin
            cnt <= cnt - CW'(1);
          end else begin
            ready <= 1'b1;
            fault <= acc_fault;
            if (acc_fault)       read_data <= '0;
            else if (!cap_write) read_data <= ram_rdata;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_ReadData = read_data;
  assign o_Ready    = ready;
  assign o_Fault    = fault;

endmodule

// File: tb/tb_arm_pipelined_data_memory_responder.sv
// Directed bench for the data-memory responder at BusWidth=32, DepthWords=64, Latency=2.
module tb_arm_pipelined_data_memory_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic        wr;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ready;
  logic        stall;
  logic        fault;

  int checks   = 0;
  int failures = 0;

  arm_pipelined_data_memory_responder #(
    .BusWidth  (32),
    .DepthWords(64),
    .Latency   (2)
  ) dut (
    .i_CLK       (clk),
    .i_RESET     (rst),
    .i_MemRequest(req),
    .i_MemWrite  (wr),
    .i_Address   (addr),
    .i_WriteData (wdata),
    .o_ReadData  (rdata),
    .o_Ready     (ready),
    .o_Stall     (stall),
    .o_Fault     (fault)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One request in cycle 0, then garbage on the inputs during WAIT; returns the RESP cycle index.
  task automatic run_access(input logic w, input logic [31:0] a, input logic [31:0] d,
                            output int lat, output logic [31:0] rd, output logic flt);
    req = 1'b1; wr = w; addr = a; wdata = d;
    #1;
    check("acc_stall_c0", 32'(stall), 32'd1);
    step();
    req = 1'b0; addr = a ^ 32'h24; wdata = ~d;
    lat = -1; rd = '0; flt = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      #1;
      if (ready) begin
        lat = c; rd = rdata; flt = fault;
        break;
      end
      step();
    end
    step();
  endtask

  int          lat;
  logic [31:0] rd;
  logic        flt;

  initial begin
    rst = 1'b1; req = 1'b1; wr = 1'b0; addr = '0; wdata = '0;
    #12;
    check("rst_stall_req1", 32'(stall), 32'd1);
    req = 1'b0;
    #1;
    check("rst_stall_req0", 32'(stall), 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_ready", 32'(ready), 32'd0);
    check("rst_fault", 32'(fault), 32'd0);
    step();
    rst = 1'b0;
    step();

    // Store DEADBEEF to 0x10, cycle by cycle
    req = 1'b1; wr = 1'b1; addr = 32'h10; wdata = 32'hDEADBEEF;
    #1; check("st_stall_c0", 32'(stall), 32'd1); check("st_ready_c0", 32'(ready), 32'd0);
    step(); req = 1'b0;
    #1; check("st_stall_c1", 32'(stall), 32'd1); check("st_ready_c1", 32'(ready), 32'd0);
    step();
    #1; check("st_stall_c2", 32'(stall), 32'd1); check("st_ready_c2", 32'(ready), 32'd0);
    step();
    #1; check("st_ready_c3", 32'(ready), 32'd1); check("st_stall_c3", 32'(stall), 32'd0);
    check("st_fault_c3", 32'(fault), 32'd0); check("st_rdata_c3", rdata, 32'd0);
    step();
    check("st_ready_c4", 32'(ready), 32'd0);

    run_access(1'b0, 32'h10, 32'h0, lat, rd, flt);
    check("ld10_lat", 32'(lat), 32'd3);
    check("ld10_data", rd, 32'hDEADBEEF);
    check("ld10_fault", 32'(flt), 32'd0);

    // A store must not disturb the held load result; also preloads 0x20 and 0x34
    run_access(1'b1, 32'h20, 32'h11111111, lat, rd, flt);
    check("st20_lat", 32'(lat), 32'd3);
    check("hold_after_store", rdata, 32'hDEADBEEF);
    run_access(1'b1, 32'h34, 32'h55555555, lat, rd, flt);

    run_access(1'b0, 32'h13, 32'h0, lat, rd, flt);
    check("mis_fault", 32'(flt), 32'd1);
    check("mis_data", rd, 32'd0);
    check("fault_held_idle", 32'(fault), 32'd1);
    run_access(1'b0, 32'h100, 32'h0, lat, rd, flt);
    check("oob_fault", 32'(flt), 32'd1);
    check("oob_data", rd, 32'd0);
    run_access(1'b0, 32'h10, 32'h0, lat, rd, flt);
    check("w4_intact", rd, 32'hDEADBEEF);
    check("fault_cleared", 32'(flt), 32'd0);

    // Reset in the first WAIT cycle aborts the store
    req = 1'b1; wr = 1'b1; addr = 32'h20; wdata = 32'h12345678;
    step();
    req = 1'b0;
    rst = 1'b1;
    #1;
    check("abort_stall", 32'(stall), 32'd0);
    check("abort_rdata", rdata, 32'd0);
    step();
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      check("abort_no_ready", 32'(ready), 32'd0);
      step();
    end
    run_access(1'b0, 32'h20, 32'h0, lat, rd, flt);
    check("abort_prior", rd, 32'h11111111);

    // Captured address/data used despite changes during WAIT (run_access perturbs them)
    run_access(1'b1, 32'h10, 32'hAAAA0001, lat, rd, flt);
    run_access(1'b0, 32'h10, 32'h0, lat, rd, flt);
    check("cap_target", rd, 32'hAAAA0001);
    run_access(1'b0, 32'h34, 32'h0, lat, rd, flt);
    check("cap_neighbor", rd, 32'h55555555);

    // Request held high: accepts every 4 cycles, stall low only on RESP
    req = 1'b1; wr = 1'b0; addr = 32'h10;
    for (int c = 0; c < 12; c++) begin
      #1;
      check($sformatf("held_stall_c%0d", c), 32'(stall), (c % 4 == 3) ? 32'd0 : 32'd1);
      check($sformatf("held_ready_c%0d", c), 32'(ready), (c % 4 == 3) ? 32'd1 : 32'd0);
      step();
    end
    req = 1'b0;
    step(); step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
